// File: rtl/stack_pkg.sv
// Shared definitions for the PUSH/POP stack controller.
//   STACK_DEPTH / STACK_CNT_W : stack entry count and occupancy counter width
//   STACK_FULL                : STACK_DEPTH expressed in counter width
//   stk_state_t               : controller FSM states
//   stk_ops_t                 : per-slot push/pop bundle
//   stk_flags_t               : sticky fault flags
package stack_pkg;

  localparam int STACK_DEPTH = 1024;
  localparam int STACK_CNT_W = $clog2(STACK_DEPTH) + 1;

  localparam logic [STACK_CNT_W-1:0] STACK_FULL = STACK_CNT_W'(STACK_DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } stk_state_t;

  typedef struct packed {
    logic push0;
    logic pop0;
    logic push1;
    logic pop1;
  } stk_ops_t;

  typedef struct packed {
    logic ovfl;
    logic unfl;
    logic illegal;
  } stk_flags_t;

endpackage

// File: rtl/stack_op_legalize.sv
// Combinational legalizer for one issued instruction pair.
//   ops_i     : raw per-slot push/pop decodes
//   occ_i     : current committed occupancy C
//   ops_o     : strobes that may safely reach the stack
//   delta_o   : signed net change (#push - #pop) of ops_o, -2..+2
//   ovfl_o    : a push was dropped (stack full)
//   unfl_o    : a pop was dropped (stack empty)
//   illegal_o : a slot decoded both PUSH and POP
module stack_op_legalize
  import stack_pkg::*;
(
  input  stk_ops_t                ops_i,
  input  logic [STACK_CNT_W-1:0]  occ_i,
  output stk_ops_t                ops_o,
  output logic signed [2:0]       delta_o,
  output logic                    ovfl_o,
  output logic                    unfl_o,
  output logic                    illegal_o
);

  logic ill0, ill1;
  logic p0, q0, p1, q1;
  logic [STACK_CNT_W-1:0] occ_mid;
  logic [1:0] n_push, n_pop;

  always_comb begin
    ill0 = ops_i.push0 & ops_i.pop0;
    ill1 = ops_i.push1 & ops_i.pop1;
    // A slot decoding both operations is reduced to a NOP.
    p0 = ops_i.push0 & ~ill0;
    q0 = ops_i.pop0  & ~ill0;
    p1 = ops_i.push1 & ~ill1;
    q1 = ops_i.pop1  & ~ill1;

    ops_o     = '0;
    ovfl_o    = 1'b0;
    unfl_o    = 1'b0;
    illegal_o = ill0 | ill1;
    occ_mid   = occ_i;

    if (p0 && q1) begin
      // Push-then-pop is bypassed inside the stack, so it is legal even when full.
      ops_o.push0 = 1'b1;
      ops_o.pop1  = 1'b1;
    end else begin
      // Slot 0 is judged on C, slot 1 on the occupancy slot 0 leaves behind.
      if (p0) begin
        if (occ_i == STACK_FULL) begin
          ovfl_o = 1'b1;
        end else begin
          ops_o.push0 = 1'b1;
          occ_mid     = occ_i + 1'b1;
        end
      end
      if (q0) begin
        if (occ_i == '0) begin
          unfl_o = 1'b1;
        end else begin
          ops_o.pop0 = 1'b1;
          occ_mid    = occ_i - 1'b1;
        end
      end
      if (p1) begin
        if (occ_mid == STACK_FULL) ovfl_o = 1'b1;
        else                       ops_o.push1 = 1'b1;
      end
      if (q1) begin
        if (occ_mid == '0) unfl_o = 1'b1;
        else               ops_o.pop1 = 1'b1;
      end
    end

    n_push  = {1'b0, ops_o.push0} + {1'b0, ops_o.push1};
    n_pop   = {1'b0, ops_o.pop0}  + {1'b0, ops_o.pop1};
    delta_o = $signed({1'b0, n_push}) - $signed({1'b0, n_pop});
  end

endmodule

// File: rtl/stack_op_ctrl.sv
// ID/EX-stage controller in front of the dual-port PUSH/POP stack.
// Legalizes each issued pair against the committed occupancy, registers the
// surviving strobes into EX, tracks occupancy and raises sticky faults that
// freeze stack traffic until err_clr.
//   clk, rst                 : clock, asynchronous active-high reset
//   stall_ID_EX, flush_ID_EX : pipeline hold / squash
//   id_push0/1, id_pop0/1    : per-slot decodes from ID
//   err_clr                  : leave FAULT and clear sticky flags
//   push0/pop0/push1/pop1    : registered EX strobes to the stack
//   occupancy                : committed entry count 0..DEPTH
//   stk_ovfl/unfl/illegal    : sticky fault flags, stk_fault is their OR
//   fsm_state                : current controller state (observability)
module stack_op_ctrl
  import stack_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_ID_EX,
  input  logic                   flush_ID_EX,
  input  logic                   id_push0,
  input  logic                   id_pop0,
  input  logic                   id_push1,
  input  logic                   id_pop1,
  input  logic                   err_clr,
  output logic                   push0,
  output logic                   pop0,
  output logic                   push1,
  output logic                   pop1,
  output logic [STACK_CNT_W-1:0] occupancy,
  output logic                   stk_ovfl,
  output logic                   stk_unfl,
  output logic                   stk_illegal,
  output logic                   stk_fault,
  output stk_state_t             fsm_state
);

  stk_state_t             state_q, state_d;
  stk_ops_t               ops_q, ops_d;
  stk_flags_t             flags_q, flags_d;
  logic [STACK_CNT_W-1:0] occ_q, occ_d;

  stk_ops_t               id_ops;
  stk_ops_t               leg_ops;
  logic signed [2:0]      leg_delta;
  stk_flags_t             leg_flags;

  assign id_ops = '{push0: id_push0, pop0: id_pop0, push1: id_push1, pop1: id_pop1};

  stack_op_legalize u_legalize (
    .ops_i     (id_ops),
    .occ_i     (occ_q),
    .ops_o     (leg_ops),
    .delta_o   (leg_delta),
    .ovfl_o    (leg_flags.ovfl),
    .unfl_o    (leg_flags.unfl),
    .illegal_o (leg_flags.illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ops_q   <= '0;
      flags_q <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      flags_q <= flags_d;
      occ_q   <= occ_d;
    end
  end

  // Stall freezes everything, including err_clr and any new fault.
  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    flags_d = flags_q;
    occ_d   = occ_q;
    if (!stall_ID_EX) begin
      case (state_q)
        RUN: begin
          if (err_clr) flags_d = '0;
          if (flush_ID_EX) begin
            ops_d = '0;
          end else begin
            ops_d   = leg_ops;
            // Sign-extend the delta; legalization guarantees no wrap.
            occ_d   = occ_q + {{(STACK_CNT_W-3){leg_delta[2]}}, leg_delta};
            flags_d = flags_d | leg_flags;
            if (|leg_flags) state_d = FAULT;
          end
        end
        FAULT: begin
          ops_d = '0;
          if (err_clr) begin
            flags_d = '0;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign push0       = ops_q.push0;
  assign pop0        = ops_q.pop0;
  assign push1       = ops_q.push1;
  assign pop1        = ops_q.pop1;
  assign occupancy   = occ_q;
  assign stk_ovfl    = flags_q.ovfl;
  assign stk_unfl    = flags_q.unfl;
  assign stk_illegal = flags_q.illegal;
  assign stk_fault   = |flags_q;
  assign fsm_state   = state_q;

endmodule
